// File: rtl/clock_pkg.sv
// Shared BCD helpers for the clock/timer counters.
package clock_pkg;

    localparam int unsigned BCD_W = 4;
    localparam int unsigned CNT_W = 2 * BCD_W;

    // Tens digit of (modulus-1), used as the wrap target.
    function automatic logic [BCD_W-1:0] bcd_top_tens(input int unsigned modulus);
        return BCD_W'((modulus - 1) / 10);
    endfunction

    // Units digit of (modulus-1), used as the wrap target.
    function automatic logic [BCD_W-1:0] bcd_top_units(input int unsigned modulus);
        return BCD_W'((modulus - 1) % 10);
    endfunction

    // A nibble is a valid BCD digit when it is 0..9.
    function automatic logic is_bcd(input logic [BCD_W-1:0] nibble);
        return nibble <= BCD_W'(9);
    endfunction

endpackage

// File: rtl/bcd_digit_dn.sv
// One BCD down-counting digit with load and a programmable underflow target.
module bcd_digit_dn
    import clock_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             ld,
    input  logic [BCD_W-1:0] din,
    input  logic [BCD_W-1:0] top,
    output logic [BCD_W-1:0] q,
    output logic             borrow
);

    // Borrow when asked to decrement while already at zero.
    assign borrow = en & (q == '0);

    // Load has priority over decrement; zero reloads from top.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (ld) begin
            q <= din;
        end else if (en) begin
            if (q == '0) begin
                q <= top;
            end else begin
                q <= q - BCD_W'(1);
            end
        end
    end

endmodule

// File: rtl/countdown_60.sv
// Cascadable two-digit BCD modulo-MOD down-counter with load clamping.
module countdown_60
    import clock_pkg::*;
#(
    parameter int unsigned MOD  = 60,
    parameter bit          WRAP = 1'b1
) (
    input  logic             CP,
    input  logic             reset,
    input  logic             EN,
    input  logic             LD,
    input  logic [CNT_W-1:0] Din,
    output logic [CNT_W-1:0] Cnt,
    output logic             BO,
    output logic             ZERO,
    output logic             ERR
);

    localparam logic [BCD_W-1:0] TOP_TENS  = bcd_top_tens(MOD);
    localparam logic [BCD_W-1:0] TOP_UNITS = bcd_top_units(MOD);
    localparam logic [CNT_W-1:0] TOP_BIN   = CNT_W'(MOD - 1);

    logic [BCD_W-1:0] units_q;
    logic [BCD_W-1:0] tens_q;
    logic [BCD_W-1:0] units_top;
    logic [BCD_W-1:0] tens_top;
    logic             units_borrow;
    logic             tens_borrow;
    logic [CNT_W-1:0] din_bin;
    logic             din_legal;
    logic [CNT_W-1:0] load_val;

    // Load validation: both nibbles BCD and value within the modulus, else clamp to MOD-1.
    assign din_bin   = CNT_W'(Din[7:4]) * CNT_W'(10) + CNT_W'(Din[3:0]);
    assign din_legal = is_bcd(Din[7:4]) & is_bcd(Din[3:0]) & (din_bin <= TOP_BIN);
    assign load_val  = din_legal ? Din : {TOP_TENS, TOP_UNITS};

    // Units reload 9 when borrowing from tens; at 00 they wrap to MOD-1 or saturate.
    assign units_top = (tens_q != '0) ? BCD_W'(9) : (WRAP ? TOP_UNITS : '0);
    assign tens_top  = WRAP ? TOP_TENS : '0;

    bcd_digit_dn u_units (
        .clk    (CP),
        .rst_n  (reset),
        .en     (EN),
        .ld     (LD),
        .din    (load_val[3:0]),
        .top    (units_top),
        .q      (units_q),
        .borrow (units_borrow)
    );

    bcd_digit_dn u_tens (
        .clk    (CP),
        .rst_n  (reset),
        .en     (units_borrow),
        .ld     (LD),
        .din    (load_val[7:4]),
        .top    (tens_top),
        .q      (tens_q),
        .borrow (tens_borrow)
    );

    assign Cnt  = {tens_q, units_q};
    assign ZERO = (Cnt == '0);
    // tens_borrow is EN with both digits at zero; a load masks it.
    assign BO   = tens_borrow & ~LD;

    // Flag an illegal (clamped) load for exactly the cycle after it.
    always_ff @(posedge CP or negedge reset) begin
        if (!reset) begin
            ERR <= 1'b0;
        end else begin
            ERR <= LD & ~din_legal;
        end
    end

endmodule
